// File: rtl/reward_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reward_rx_pkg
//  Description : Shared widths, state encoding and default memory map for the
//                reward receive path (also used by the reward sender).
//  Revision    : 1.0 - initial release
// ============================================================================
package reward_rx_pkg;

    localparam int MEM_WIDTH  = 8;
    localparam int WORD_WIDTH = 16;

    // Bytes per 16-bit word; packet fields and Q entries are word-spaced
    localparam logic [WORD_WIDTH-1:0] c_word_bytes  = 16'(WORD_WIDTH / MEM_WIDTH);
    localparam logic [WORD_WIDTH-1:0] c_off_clu     = c_word_bytes;
    localparam logic [WORD_WIDTH-1:0] c_off_rew     = c_word_bytes << 1;

    localparam logic [WORD_WIDTH-1:0] c_pkt_base    = 16'h0008;
    localparam logic [WORD_WIDTH-1:0] c_qtable_base = 16'h0048;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_A_SRC = 3'd1,
        S_A_CLU = 3'd2,
        S_A_REW = 3'd3,
        S_A_Q   = 3'd4,
        S_CALC  = 3'd5,
        S_WRITE = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    // Byte address of word idx in a word array starting at base (16-bit wrap)
    function automatic logic [WORD_WIDTH-1:0] word_addr(
        input logic [WORD_WIDTH-1:0] base,
        input logic [WORD_WIDTH-1:0] idx
    );
        return base + (idx * c_word_bytes);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reward_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : reward_rx_if
//  Description : Word-wide memory bus between the reward receiver (master)
//                and the data memory (slave). Read data is combinational
//                from the registered address.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reward_rx_if;
    import reward_rx_pkg::*;

    logic [WORD_WIDTH-1:0] address;
    logic [WORD_WIDTH-1:0] data_in;
    logic [WORD_WIDTH-1:0] data_out;
    logic                  wr_en;

    modport master (output address, output data_out, output wr_en, input  data_in);
    modport slave  (input  address, input  data_out, input  wr_en, output data_in);

endinterface
`default_nettype wire

// File: rtl/reward_rx_q_update.sv
`default_nettype none
// ============================================================================
//  Module      : reward_rx_q_update
//  Description : Combinational Q-value update: moves Q_old toward reward by
//                2^-ALPHA_SHIFT of the distance. Working on the magnitude of
//                the difference keeps the result between Q_old and reward,
//                so it can never overflow or underflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module reward_rx_q_update
    import reward_rx_pkg::*;
#(
    parameter int ALPHA_SHIFT = 1
)(
    input  wire  [WORD_WIDTH-1:0] q_old,
    input  wire  [WORD_WIDTH-1:0] reward,
    output logic [WORD_WIDTH-1:0] q_new
);

    logic                  w_up;
    logic [WORD_WIDTH-1:0] w_diff;
    logic [WORD_WIDTH-1:0] w_step;

    // Step toward the reward by the shifted absolute distance
    always_comb begin
        w_up   = (reward >= q_old);
        w_diff = w_up ? (reward - q_old) : (q_old - reward);
        w_step = w_diff >> ALPHA_SHIFT;
        q_new  = w_up ? (q_old + w_step) : (q_old - w_step);
    end

endmodule
`default_nettype wire

// File: rtl/reward_rx.sv
`default_nettype none
// ============================================================================
//  Module      : reward_rx
//  Description : Reads a received reward packet from memory, filters it
//                against this node's identity, and applies a Q-learning
//                update to the sender's Q-table entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module reward_rx
    import reward_rx_pkg::*;
#(
    parameter logic [WORD_WIDTH-1:0] PKT_BASE    = c_pkt_base,
    parameter logic [WORD_WIDTH-1:0] QTABLE_BASE = c_qtable_base,
    parameter logic [WORD_WIDTH-1:0] NUM_NODES   = 16'd64,
    parameter int                    ALPHA_SHIFT = 1
)(
    input  wire                   clock,
    input  wire                   nrst,
    input  wire                   start,
    input  wire  [WORD_WIDTH-1:0] MY_NODE_ID,
    input  wire  [WORD_WIDTH-1:0] MY_CLUSTER_ID,
    reward_rx_if.master           mem,
    output logic [WORD_WIDTH-1:0] q_new,
    output logic                  dropped,
    output logic                  done
);

    state_t                r_state;
    logic [WORD_WIDTH-1:0] r_addr;
    logic [WORD_WIDTH-1:0] r_data_out;
    logic                  r_wr_en;
    logic [WORD_WIDTH-1:0] r_q_new;
    logic                  r_dropped;
    logic                  r_done;
    logic [WORD_WIDTH-1:0] r_src;
    logic [WORD_WIDTH-1:0] r_clu;
    logic [WORD_WIDTH-1:0] r_reward;

    logic                  w_drop;
    logic [WORD_WIDTH-1:0] w_q_addr;
    logic [WORD_WIDTH-1:0] w_q_calc;

    // Packet filter and Q-table address, both from the captured header words
    always_comb begin
        w_drop   = (r_clu != MY_CLUSTER_ID) || (r_src == MY_NODE_ID) || (r_src >= NUM_NODES);
        w_q_addr = word_addr(QTABLE_BASE, r_src);
    end

    // In CALC the bus returns the current Q entry of the source node
    reward_rx_q_update #(
        .ALPHA_SHIFT (ALPHA_SHIFT)
    ) u_q_update (
        .q_old  (mem.data_in),
        .reward (r_reward),
        .q_new  (w_q_calc)
    );

    // Sequencer: each state registers the address whose data the next state
    // consumes, so every capture happens on the exit edge of its state
    always_ff @(posedge clock) begin
        if (!nrst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_data_out <= '0;
            r_wr_en    <= 1'b0;
            r_q_new    <= '0;
            r_dropped  <= 1'b0;
            r_done     <= 1'b0;
            r_src      <= '0;
            r_clu      <= '0;
            r_reward   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_addr     <= '0;
                    r_wr_en    <= 1'b0;
                    r_data_out <= '0;
                    if (start) begin
                        r_state <= S_A_SRC;
                    end
                end
                S_A_SRC: begin
                    r_addr  <= PKT_BASE;
                    r_state <= S_A_CLU;
                end
                S_A_CLU: begin
                    r_addr  <= PKT_BASE + c_off_clu;
                    r_src   <= mem.data_in;
                    r_state <= S_A_REW;
                end
                S_A_REW: begin
                    r_addr  <= PKT_BASE + c_off_rew;
                    r_clu   <= mem.data_in;
                    r_state <= S_A_Q;
                end
                S_A_Q: begin
                    r_reward <= mem.data_in;
                    if (w_drop) begin
                        r_dropped <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_addr    <= w_q_addr;
                        r_dropped <= 1'b0;
                        r_state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_q_new    <= w_q_calc;
                    r_data_out <= w_q_calc;
                    r_wr_en    <= 1'b1;
                    r_state    <= S_WRITE;
                end
                S_WRITE: begin
                    r_wr_en    <= 1'b0;
                    r_data_out <= '0;
                    r_done     <= 1'b1;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    if (!start) begin
                        r_done  <= 1'b0;
                        r_addr  <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem.address  = r_addr;
    assign mem.data_out = r_data_out;
    assign mem.wr_en    = r_wr_en;
    assign q_new        = r_q_new;
    assign dropped      = r_dropped;
    assign done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_reward_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reward_rx
//  Description : Self-checking bench for reward_rx: directed and random
//                packets against a behavioural reference model, plus reset
//                abort and start-hold scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reward_rx;

    localparam logic [15:0] NODE_ID = 16'd3;
    localparam logic [15:0] NODE_CLU = 16'd1;
    localparam int PKT = 16'h0008;
    localparam int QTB = 16'h0048;

    logic        clock;
    logic        nrst;
    logic        start;
    logic [15:0] my_node;
    logic [15:0] my_clu;
    logic [15:0] q_new;
    logic        dropped;
    logic        done;

    reward_rx_if bus ();

    reward_rx #(
        .PKT_BASE    (16'h0008),
        .QTABLE_BASE (16'h0048),
        .NUM_NODES   (16'd64),
        .ALPHA_SHIFT (1)
    ) dut (
        .clock         (clock),
        .nrst          (nrst),
        .start         (start),
        .MY_NODE_ID    (my_node),
        .MY_CLUSTER_ID (my_clu),
        .mem           (bus),
        .q_new         (q_new),
        .dropped       (dropped),
        .done          (done)
    );

    // Extreme learning rates exercised directly on the update block
    logic [15:0] t_qold, t_rew, t_q0, t_q15;
    reward_rx_q_update #(.ALPHA_SHIFT(0))  u_q0  (.q_old(t_qold), .reward(t_rew), .q_new(t_q0));
    reward_rx_q_update #(.ALPHA_SHIFT(15)) u_q15 (.q_old(t_qold), .reward(t_rew), .q_new(t_q15));

    // Word-addressed memory with combinational read
    logic [15:0] mem [0:32767];
    assign bus.data_in = mem[bus.address[15:1]];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Write observer
    int          wr_total = 0;
    logic [15:0] wr_last_addr = '0;
    logic [15:0] wr_last_data = '0;
    always @(posedge clock) begin
        if (bus.wr_en === 1'b1) begin
            wr_total     <= wr_total + 1;
            wr_last_addr <= bus.address;
            wr_last_data <= bus.data_out;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_qnew = '0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: move q_old toward reward by distance / 2^s, rounded toward q_old
    function automatic int model_q(input int qold, input int rew, input int s);
        int d;
        d = rew - qold;
        if (d >= 0) return qold + d / (1 << s);
        else        return qold - (-d) / (1 << s);
    endfunction

    // One complete operation; hold>0 keeps start high that many cycles in DONE
    task automatic run_op(input logic [15:0] src, input logic [15:0] clu,
                          input logic [15:0] rew, input logic [15:0] qold,
                          input int hold);
        bit          drop;
        logic [15:0] qaddr;
        int          exp_q, lat, bad, w0, held_bad;
        drop  = (clu != NODE_CLU) || (src == NODE_ID) || (int'(src) >= 64);
        qaddr = 16'(QTB + 2 * int'(src));
        mem[PKT/2]     = src;
        mem[PKT/2 + 1] = clu;
        mem[PKT/2 + 2] = rew;
        if (!drop) mem[qaddr[15:1]] = qold;
        exp_q = model_q(int'(qold), int'(rew), 1);

        @(negedge clock);
        start = 1'b1;
        w0 = wr_total;
        @(posedge clock);
        #1 start = 1'($urandom_range(0, 1));
        lat = -1;
        bad = 0;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(posedge clock);
            #1;
            if (i == 2) start = (hold > 0);
            if (!bus.wr_en && bus.data_out != 16'd0) bad++;
            if (done && lat < 0) lat = i;
        end
        check("latency", lat, drop ? 4 : 6);
        check("dropped", int'(dropped), int'(drop));
        check("wr_count", wr_total - w0, drop ? 0 : 1);
        if (!drop) begin
            exp_qnew = 16'(exp_q);
            check("wr_addr", int'(wr_last_addr), int'(qaddr));
            check("wr_data", int'(wr_last_data), exp_q);
        end
        check("q_new", int'(q_new), int'(exp_qnew));
        check("dout_idle", bad, 0);

        if (hold > 0) begin
            held_bad = 0;
            for (int j = 0; j < hold; j++) begin
                @(posedge clock);
                #1;
                if (!done) held_bad++;
            end
            check("done_hold", held_bad, 0);
            check("hold_no_rerun", wr_total - w0, drop ? 0 : 1);
            @(negedge clock);
            start = 1'b0;
        end
        @(posedge clock);
        #1;
        check("done_clear", int'(done), 0);
        check("idle_addr", int'(bus.address), 0);
    endtask

    // Abort an accepted operation with reset after `when` edges (4=CALC, 5=WRITE)
    task automatic reset_mid(input int when);
        int snap, bad;
        mem[PKT/2]     = 16'd7;
        mem[PKT/2 + 1] = NODE_CLU;
        mem[PKT/2 + 2] = 16'd900;
        mem[(QTB + 14) / 2] = 16'd100;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        for (int i = 1; i <= when; i++) @(posedge clock);
        #1 nrst = 1'b0;
        @(posedge clock);
        #1;
        snap = wr_total;
        exp_qnew = '0;
        check("rst_addr", int'(bus.address), 0);
        check("rst_dout", int'(bus.data_out), 0);
        check("rst_wr_en", int'(bus.wr_en), 0);
        check("rst_q_new", int'(q_new), 0);
        check("rst_flags", int'({dropped, done}), 0);
        bad = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock);
            #1;
            if (done || bus.address != 16'd0) bad++;
        end
        check("rst_hold_start", bad, 0);
        @(negedge clock);
        nrst  = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) @(posedge clock);
        #1;
        check("rst_no_write", wr_total - snap, 0);
        run_op(16'd5, NODE_CLU, 16'd100, 16'd60, 0);
    endtask

    initial begin
        logic [15:0] s, c;
        for (int i = 0; i < 32768; i++) mem[i] = '0;
        nrst    = 1'b0;
        start   = 1'b0;
        my_node = NODE_ID;
        my_clu  = NODE_CLU;
        t_qold  = '0;
        t_rew   = '0;
        repeat (3) @(posedge clock);
        #1;
        check("por_addr", int'(bus.address), 0);
        check("por_outs", int'({bus.wr_en, dropped, done, q_new, bus.data_out}), 0);
        @(negedge clock);
        nrst = 1'b1;

        // Directed: accepted updates, then the three drop reasons, range edge
        run_op(16'd5,  NODE_CLU, 16'd100, 16'd60,  0);
        run_op(16'd5,  NODE_CLU, 16'd40,  16'd100, 0);
        run_op(16'd5,  NODE_CLU, 16'd61,  16'd60,  2);
        run_op(16'd5,  16'd2,    16'd100, 16'd0,   0);
        run_op(16'd3,  NODE_CLU, 16'd100, 16'd0,   0);
        run_op(16'd64, NODE_CLU, 16'd100, 16'd0,   3);
        run_op(16'd63, NODE_CLU, 16'hFFFF, 16'd0,  0);
        run_op(16'd0,  NODE_CLU, 16'd0,   16'hFFFF, 0);

        // Random packets
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       s = NODE_ID;
                1:       s = 16'($urandom_range(64, 65535));
                default: s = 16'($urandom_range(0, 63));
            endcase
            c = ($urandom_range(0, 3) == 0) ? 16'($urandom) : NODE_CLU;
            run_op(s, c, 16'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0) ? 2 : 0);
        end

        // Reset during CALC and during WRITE
        reset_mid(4);
        reset_mid(5);

        // Extreme learning rates
        t_qold = 16'd10; t_rew = 16'hFFFF; #1;
        check("shift0_max", int'(t_q0), 65535);
        t_qold = 16'd0;  t_rew = 16'hFFFF; #1;
        check("shift15_max", int'(t_q15), 1);
        for (int n = 0; n < 20; n++) begin
            t_qold = 16'($urandom);
            t_rew  = 16'($urandom);
            #1;
            check("shift0_rand", int'(t_q0), model_q(int'(t_qold), int'(t_rew), 0));
            check("shift15_rand", int'(t_q15), model_q(int'(t_qold), int'(t_rew), 15));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reward_rx.md
REWARD_RX -- requirements
Module: reward_rx

Interface
REQ-001 Parameter PKT_BASE, default 16'h0008, byte address of word 0 of the received reward packet (src node ID, src cluster ID, reward value at +0, +2, +4).
REQ-002 Parameter QTABLE_BASE, default 16'h0048, byte address of Q-table entry 0; entry n at QTABLE_BASE + 2*n.
REQ-003 Parameter NUM_NODES, default 16'd64, number of valid Q-table entries; legal src IDs are 0..NUM_NODES-1.
REQ-004 Parameter ALPHA_SHIFT, default 1, learning-rate right-shift (alpha = 2^-ALPHA_SHIFT), legal range 0..15.
REQ-005 clock  input  1  rising-edge clock.
REQ-006 nrst  input  1  synchronous, active-low reset.
REQ-007 start  input  1  level request; sampled in IDLE.
REQ-008 MY_NODE_ID  input  16  this node's ID.
REQ-009 MY_CLUSTER_ID  input  16  this node's cluster ID.
REQ-010 data_in  input  16  memory read data; valid the cycle after address is driven.
REQ-011 address  output  16  memory byte address (registered).
REQ-012 data_out  output  16  memory write data; meaningful only while wr_en=1.
REQ-013 wr_en  output  1  one-cycle memory write strobe.
REQ-014 q_new  output  16  last computed Q value; held until next computation.
REQ-015 dropped  output  1  packet rejected in last operation; valid with done.
REQ-016 done  output  1  operation complete.

Function
REQ-017 States: IDLE, A_SRC, A_CLU, A_REW, A_Q, CALC, WRITE, DONE; one transition per clock.
REQ-018 IDLE: address=0, wr_en=0; start=1 -> A_SRC; else stay.
REQ-019 A_SRC drives address=PKT_BASE; -> A_CLU.
REQ-020 A_CLU drives address=PKT_BASE+2; captures data_in as src at exit; -> A_REW.
REQ-021 A_REW drives address=PKT_BASE+4; captures data_in as clu at exit; -> A_Q.
REQ-022 A_Q captures data_in as reward at exit; drop condition = clu!=MY_CLUSTER_ID, or src==MY_NODE_ID, or src>=NUM_NODES.
REQ-023 A_Q with drop: address stays PKT_BASE+4, dropped<=1, -> DONE (no write, q_new unchanged).
REQ-024 A_Q without drop: drives address=QTABLE_BASE+2*src (16-bit wrap), dropped<=0, -> CALC.
REQ-025 CALC: Q_old=data_in; if reward>=Q_old, q_new=Q_old+((reward-Q_old)>>ALPHA_SHIFT), else q_new=Q_old-((Q_old-reward)>>ALPHA_SHIFT); unsigned 16-bit, result always between Q_old and reward, no overflow; -> WRITE.
REQ-026 WRITE: address=QTABLE_BASE+2*src, data_out=q_new, wr_en=1 for exactly this cycle; write issued even if q_new==Q_old; -> DONE.
REQ-027 DONE: done=1; stays while start=1; start=0 -> IDLE with done=0 next cycle.
REQ-028 Latency: start sampled high at edge k -> done high after edge k+6 (accepted) or k+4 (dropped).
REQ-029 start changes while not in IDLE/DONE are ignored; MY_NODE_ID/MY_CLUSTER_ID must be stable during an operation.
REQ-030 data_out=0 whenever wr_en=0.

Reset
REQ-031 nrst=0 at a rising edge: state=IDLE, address=0, data_out=0, wr_en=0, q_new=0, dropped=0, done=0, captured src/clu/reward=0.
REQ-032 Reset overrides any state, including WRITE; no partial write after reset edge; reset with start=1 enters A_SRC only on the first edge after nrst=1.

Structure
REQ-033 Shared package holds MEM_WIDTH=8, WORD_WIDTH=16, state encoding, and default PKT_BASE/QTABLE_BASE constants shared with reward.
REQ-034 One sub-module q_update (combinational: Q_old, reward, ALPHA_SHIFT -> q_new); everything else in reward_rx.

Verification
REQ-035 MY_NODE_ID=3, MY_CLUSTER_ID=1, packet {5,1,100}, mem[0x52]=60, ALPHA_SHIFT=1 -> one write 0x52<=80, q_new=80, dropped=0, done 7 cycles after start.
REQ-036 Same setup, mem[0x52]=100, reward=40 -> write 0x52<=70; reward=61, Q_old=60 -> write 0x52<=60.
REQ-037 Packet {5,2,100} (cluster mismatch) or {3,1,100} (self) or {64,1,100} (out of range) -> no wr_en, dropped=1, done 5 cycles after start, q_new unchanged.
REQ-038 ALPHA_SHIFT=0, Q_old=10, reward=65535 -> write 65535; ALPHA_SHIFT=15, Q_old=0, reward=65535 -> write 1.
REQ-039 nrst low during CALC and during WRITE -> no wr_en on any later cycle, all outputs 0, next start runs full clean sequence.
REQ-040 start held high through DONE -> done stays 1, no second operation; start low -> IDLE, then new start repeats sequence.
